// File: rtl/temp_ascii_pkg.sv
// Shared constants for the temperature ASCII transmitter: FSM encoding,
// ASCII byte values, frame sizing and BCD helpers for threshold arithmetic.
package temp_ascii_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_DOT  = 8'h2E;
    localparam logic [7:0] ASC_C    = 8'h43;
    localparam logic [7:0] ASC_QM   = 8'h3F;
    localparam logic [7:0] ASC_BANG = 8'h21;
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;

    // Three integer digits, '.', tenths, 'C', optional '!', CR, LF.
    localparam int FRAME_MAX = 9;

    function automatic int bcd_to_bin(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] bin_to_bcd(input int v);
        int x;
        x = (v < 0) ? 0 : v;
        return {4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

endpackage

// File: rtl/bcd_digit_ascii.sv
// One BCD digit to its ASCII character; codes above 9 become '?'.
module bcd_digit_ascii
    import temp_ascii_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    assign ascii = (bcd > 4'd9) ? ASC_QM : (ASC_ZERO + {4'd0, bcd});

endmodule

// File: rtl/temp_ascii_tx.sv
// Sends each new temperature reading as an ASCII line ("25.3C\r\n") over a
// valid/ready byte port. Optional over-temperature flag: TEMP_ASCII_TX_ALARM_EN.
module temp_ascii_tx
    import temp_ascii_pkg::*;
#(
    parameter int          SETTLE_CYC    = 32,
    parameter logic [11:0] ALARM_THR_BCD = 12'h085,
    parameter int          ALARM_HYST    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] temp_ent_bcd,
    input  logic [3:0]  temp_dec_bcd,
    input  logic        sample_tgl,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        alarm
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC);

    logic [2:0]  state;
    logic        tgl_q;
    logic        tgl_edge;
    logic        pending;
    logic [7:0]  cnt;
    logic [3:0]  idx;
    logic        tx_valid_q;
    logic        alarm_q;
    logic [11:0] snap_ent;
    logic [3:0]  snap_dec;

    logic [3:0][3:0]            snap_dig;
    logic [3:0][7:0]            asc;
    logic [FRAME_MAX-1:0][7:0]  frame;
    logic [3:0]                 frame_len;
    logic [3:0]                 n;

    assign tgl_edge = sample_tgl ^ tgl_q;

    // Digit 3 = hundreds ... digit 0 = tenths, all taken from the snapshot.
    assign snap_dig = {snap_ent, snap_dec};

    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_ascii u_dig (
            .bcd   (snap_dig[g]),
            .ascii (asc[g])
        );
    end

    // Pack the line from the left; suppressed leading zeros simply take no slot.
    always_comb begin
        frame = '0;
        n     = 4'd0;
        if (snap_dig[3] != 4'd0) begin
            frame[n] = asc[3];
            n        = n + 4'd1;
        end
        if (snap_dig[3] != 4'd0 || snap_dig[2] != 4'd0) begin
            frame[n] = asc[2];
            n        = n + 4'd1;
        end
        frame[n] = asc[1];   n = n + 4'd1;
        frame[n] = ASC_DOT;  n = n + 4'd1;
        frame[n] = asc[0];   n = n + 4'd1;
        frame[n] = ASC_C;    n = n + 4'd1;
        if (alarm_q) begin
            frame[n] = ASC_BANG;
            n        = n + 4'd1;
        end
        frame[n] = ASC_CR;   n = n + 4'd1;
        frame[n] = ASC_LF;   n = n + 4'd1;
        frame_len = n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tgl_q      <= 1'b0;
            pending    <= 1'b0;
            cnt        <= 8'd0;
            idx        <= 4'd0;
            tx_valid_q <= 1'b0;
            snap_ent   <= 12'd0;
            snap_dec   <= 4'd0;
        end else begin
            tgl_q <= sample_tgl;
            case (state)
                ST_IDLE: begin
                    if (tgl_edge) begin
                        state <= ST_SETTLE;
                        cnt   <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (tgl_edge) pending <= 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_LATCH;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (tgl_edge) pending <= 1'b1;
                    snap_ent   <= temp_ent_bcd;
                    snap_dec   <= temp_dec_bcd;
                    idx        <= 4'd0;
                    tx_valid_q <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tgl_edge) pending <= 1'b1;
                    // tx_valid is held high for the whole of SEND, so ready alone is the handshake.
                    if (tx_ready) begin
                        if (idx == frame_len - 4'd1) begin
                            tx_valid_q <= 1'b0;
                            idx        <= 4'd0;
                            state      <= ST_DONE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    tx_valid_q <= 1'b0;
                    if (pending || tgl_edge) begin
                        pending <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= ST_SETTLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TEMP_ASCII_TX_ALARM_EN
    localparam logic [11:0] ALARM_CLR_BCD =
        bin_to_bcd(bcd_to_bin(ALARM_THR_BCD) - ALARM_HYST);

    // Valid BCD orders like binary, so the raw 12-bit compare is a numeric compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else if (state == ST_LATCH) begin
            if (temp_ent_bcd >= ALARM_THR_BCD)
                alarm_q <= 1'b1;
            else if (temp_ent_bcd < ALARM_CLR_BCD)
                alarm_q <= 1'b0;
        end
    end
`else
    assign alarm_q = 1'b0;
`endif

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_valid_q ? frame[idx] : 8'h00;
    assign busy     = (state != ST_IDLE);
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_temp_ascii_tx.sv
// Self-checking bench for temp_ascii_tx: randomized readings and ready
// patterns against a string-formatting reference model of the output line.
module tb_temp_ascii_tx;

    localparam int SETTLE = 32;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] ent = 12'h000;
    logic [3:0]  dec = 4'h0;
    logic        tgl = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        alarm;

    int n_chk  = 0;
    int n_pass = 0;
    int rdy_mode = 0;
    int stab_err = 0;
    bit hold = 0;
    logic [7:0] hold_data;
    bit model_alm = 0;
    bq_t got_q, exp_q;

    always #5 clk = ~clk;

    temp_ascii_tx #(.SETTLE_CYC(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .temp_ent_bcd (ent),
        .temp_dec_bcd (dec),
        .sample_tgl   (tgl),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .alarm        (alarm)
    );

    // Ready pattern: 0 = always, 1 = every third cycle, 2 = random.
    initial begin
        int rc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (rc % 3 == 2);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            rc++;
        end
    end

    // Collect accepted bytes; a byte offered but not taken must reappear unchanged.
    always @(posedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold && (!tx_valid || tx_data !== hold_data)) stab_err++;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                hold = 0;
            end else if (tx_valid) begin
                hold = 1;
                hold_data = tx_data;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic string dch(input logic [3:0] v);
        if (v > 4'd9) return "?";
        return $sformatf("%0d", v);
    endfunction

    // Reference: printf-style rendering of the reading, digit-wise only when a code is invalid.
    function automatic void model_push(input logic [11:0] e, input logic [3:0] d);
        string s;
`ifdef TEMP_ASCII_TX_ALARM_EN
        if (e >= 12'h085) model_alm = 1;
        else if (e < 12'h080) model_alm = 0;
`endif
        if (e[11:8] < 10 && e[7:4] < 10 && e[3:0] < 10 && d < 10) begin
            s = $sformatf("%0d.%0dC", e[11:8] * 100 + e[7:4] * 10 + e[3:0], d);
        end else begin
            s = "";
            if (e[11:8] != 0) s = {s, dch(e[11:8])};
            if (e[11:4] != 0) s = {s, dch(e[7:4])};
            s = {s, dch(e[3:0]), ".", dch(d), "C"};
        end
        if (model_alm) s = {s, "!"};
        s = {s, "\r\n"};
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    function automatic logic [127:0] vec(input bq_t q);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[119:0], q[i]};
        return v;
    endfunction

    function automatic logic [3:0] rdig();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic fire(input logic [11:0] e, input logic [3:0] d);
        @(posedge clk);
        #1;
        ent = e;
        dec = d;
        tgl = ~tgl;
        model_push(e, d);
    endtask

    task automatic wait_idle(output bit to);
        to = 1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", tx_valid); else n_pass++;
        n_chk++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", tx_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_chk++; if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b exp 0", alarm); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_latency();
        int lat = 0;
        bit to;
        rdy_mode = 0;
        got_q.delete(); exp_q.delete();
        fire(12'h025, 4'h3);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            lat++;
            #1;
            if (tx_valid) break;
        end
        n_chk++; if (lat !== SETTLE + 3) $display("FAIL latency: got %0d exp %0d", lat, SETTLE + 3); else n_pass++;
        wait_idle(to);
        n_chk++; if (to) $display("FAIL latency_timeout: busy still high"); else n_pass++;
        n_chk++;
        if (got_q.size() != 7 || vec(got_q) !== 128'h32352E33430D0A)
            $display("FAIL frame_25_3: got %h exp 32352e33430d0a", vec(got_q));
        else n_pass++;
    endtask

    task automatic test_alarm();
        logic [11:0] rd [5] = '{12'h084, 12'h085, 12'h081, 12'h080, 12'h079};
`ifdef TEMP_ASCII_TX_ALARM_EN
        bit ea [5] = '{0, 1, 1, 1, 0};
`else
        bit ea [5] = '{0, 0, 0, 0, 0};
`endif
        bit to;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            got_q.delete(); exp_q.delete();
            fire(rd[i], 4'h5);
            wait_idle(to);
            n_chk++; if (to) $display("FAIL alarm_timeout %0d", i); else n_pass++;
            n_chk++; if (alarm !== ea[i]) $display("FAIL alarm_%0d: got %b exp %b", i, alarm, ea[i]); else n_pass++;
            n_chk++;
            if (got_q.size() != exp_q.size() || vec(got_q) !== vec(exp_q))
                $display("FAIL alarm_frame_%0d: got %h exp %h", i, vec(got_q), vec(exp_q));
            else n_pass++;
        end
    endtask

    task automatic test_frames();
        logic [11:0] es [7] = '{12'h000, 12'h105, 12'h0A2, 12'hF09, 12'h009, 12'h999, 12'h010};
        logic [3:0]  ds [7] = '{4'h7,    4'h0,    4'h5,    4'hA,    4'h9,    4'h9,    4'h0};
        bit to;
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) begin
            got_q.delete(); exp_q.delete();
            fire(es[i], ds[i]);
            wait_idle(to);
            n_chk++; if (to) $display("FAIL frames_timeout %0d", i); else n_pass++;
            n_chk++;
            if (got_q.size() != exp_q.size() || vec(got_q) !== vec(exp_q))
                $display("FAIL frame_%03h_%h: got %h exp %h", es[i], ds[i], vec(got_q), vec(exp_q));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        logic [3:0] d;
        bit to;
        rdy_mode = 2;
        for (int i = 0; i < 15; i++) begin
            got_q.delete(); exp_q.delete();
            e = {($urandom_range(0, 2) == 0) ? rdig() : 4'd0, rdig(), rdig()};
            d = rdig();
            fire(e, d);
            wait_idle(to);
            n_chk++;
            if (to || got_q.size() != exp_q.size() || vec(got_q) !== vec(exp_q))
                $display("FAIL random_%0d (%03h.%h): got %h exp %h", i, e, d, vec(got_q), vec(exp_q));
            else n_pass++;
            n_chk++; if (alarm !== model_alm) $display("FAIL random_alarm_%0d: got %b exp %b", i, alarm, model_alm); else n_pass++;
        end
        n_chk++; if (stab_err !== 0) $display("FAIL random_stability: got %0d exp 0", stab_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to;
        bit seen = 0;
        rdy_mode = 1;
        stab_err = 0;
        got_q.delete(); exp_q.delete();
        fire(12'h047, 4'h1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1;
                break;
            end
        end
        n_chk++; if (!seen) $display("FAIL b2b_start: tx_valid never rose"); else n_pass++;
        // Two edges mid-frame plus new inputs: exactly one more frame, built from the new inputs.
        repeat (2) @(posedge clk);
        #1;
        ent = 12'h063;
        dec = 4'h8;
        tgl = ~tgl;
        repeat (3) @(posedge clk);
        #1 tgl = ~tgl;
        model_push(12'h063, 4'h8);
        wait_idle(to);
        n_chk++; if (to) $display("FAIL b2b_timeout: busy still high"); else n_pass++;
        n_chk++;
        if (got_q.size() != exp_q.size() || vec(got_q) !== vec(exp_q))
            $display("FAIL b2b_frames: got %0d bytes %h exp %0d bytes %h",
                     got_q.size(), vec(got_q), exp_q.size(), vec(exp_q));
        else n_pass++;
        n_chk++; if (stab_err !== 0) $display("FAIL b2b_stability: got %0d exp 0", stab_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen = 0;
        rdy_mode = 1;
        got_q.delete(); exp_q.delete();
        fire(12'h090, 4'h2);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1;
                break;
            end
        end
        n_chk++; if (!seen) $display("FAIL rmid_start: tx_valid never rose"); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        n_chk++; if (tx_valid !== 1'b0) $display("FAIL rmid_valid: got %b exp 0", tx_valid); else n_pass++;
        n_chk++; if (alarm !== 1'b0) $display("FAIL rmid_alarm: got %b exp 0", alarm); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b exp 0", busy); else n_pass++;
        model_alm = 0;
        tgl = 1'b1;
        repeat (2) @(posedge clk);
        got_q.delete(); exp_q.delete();
        model_push(12'h090, 4'h2);
        #1 rst_n = 1;
        wait_idle(to);
        n_chk++; if (to) $display("FAIL rmid_timeout: busy still high"); else n_pass++;
        n_chk++;
        if (got_q.size() != exp_q.size() || vec(got_q) !== vec(exp_q))
            $display("FAIL rmid_frame: got %h exp %h", vec(got_q), vec(exp_q));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_alarm();
        test_frames();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
